// File: rtl/inertial_integrator.sv
// rtl/inertial_integrator.sv - gyro offset calibration and pitch-rate integrator
// Accelerometer fusion toward AZ-derived pitch is built only with INERTIAL_FUSION_EN defined.
module inertial_integrator #(
  parameter int                 CAL_LOG2  = 4,
  parameter logic signed [15:0] AZ_OFFSET = 16'sh0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               smpl_vld,
  input  logic signed [15:0] ptch_rt_raw,
  input  logic signed [15:0] AZ,
  input  logic               clr_int,
  output logic signed [15:0] ptch,
  output logic signed [15:0] ptch_rt,
  output logic               vld,
  output logic               cal_done
);

  localparam int AW = 16 + CAL_LOG2;
  localparam logic signed [28:0] INT_MAX = 29'sd67108863;
  localparam logic signed [28:0] INT_MIN = -29'sd67108864;

  typedef enum logic {CAL, RUN} state_t;
  state_t state_q, state_d;

  logic signed [AW-1:0]   acc_q, acc_d;
  logic [CAL_LOG2-1:0]    cnt_q, cnt_d;
  logic signed [15:0]     offset_q, offset_d;
  logic signed [26:0]     int_q, int_d;
  logic signed [15:0]     ptch_rt_q, ptch_rt_d;
  logic                   vld_q, vld_d;

  logic                   cal_smpl, cal_last, run_smpl, run_clr;
  logic signed [AW-1:0]   acc_sum;
  logic signed [16:0]     diff;
  logic signed [15:0]     rt_corr;
  logic signed [15:0]     ptch_cur;
  logic signed [11:0]     fus;
  logic signed [28:0]     int_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= CAL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == CAL && cal_last) state_d = RUN;
  end

  // A clear coinciding with a sample drops that sample.
  always_comb begin
    cal_smpl = (state_q == CAL) && smpl_vld;
    cal_last = cal_smpl && (&cnt_q);
    run_clr  = (state_q == RUN) && clr_int;
    run_smpl = (state_q == RUN) && smpl_vld && !clr_int;
    cal_done = (state_q == RUN);
  end

  assign ptch_cur = int_q[26:11];

`ifdef INERTIAL_FUSION_EN
  logic signed [15:0] az_comp;
  logic signed [25:0] prod;
  logic signed [15:0] ptch_acc;

  always_comb begin
    az_comp  = AZ - AZ_OFFSET;
    prod     = 26'(az_comp) * 26'sd327;
    ptch_acc = 16'(prod >>> 13);
    if (ptch_acc > ptch_cur)      fus = 12'sd1024;
    else if (ptch_acc < ptch_cur) fus = -12'sd1024;
    else                          fus = '0;
  end
`else
  logic unused_az;
  assign unused_az = ^{AZ, AZ_OFFSET};
  assign fus       = '0;
`endif

  always_comb begin
    acc_sum = acc_q + AW'(ptch_rt_raw);
    diff    = 17'(ptch_rt_raw) - 17'(offset_q);
    if (diff[16] != diff[15]) rt_corr = diff[16] ? 16'sh8000 : 16'sh7FFF;
    else                      rt_corr = diff[15:0];
    int_sum = 29'(int_q) - 29'(rt_corr) + 29'(fus);
  end

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    offset_d  = offset_q;
    int_d     = int_q;
    ptch_rt_d = ptch_rt_q;
    vld_d     = 1'b0;
    if (cal_smpl) begin
      acc_d = acc_sum;
      cnt_d = cnt_q + CAL_LOG2'(1);
      if (cal_last) offset_d = 16'(acc_sum >>> CAL_LOG2);
    end
    if (run_clr) begin
      int_d = '0;
    end else if (run_smpl) begin
      if (int_sum > INT_MAX)      int_d = 27'(INT_MAX);
      else if (int_sum < INT_MIN) int_d = 27'(INT_MIN);
      else                        int_d = 27'(int_sum);
      ptch_rt_d = rt_corr;
      vld_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      offset_q  <= '0;
      int_q     <= '0;
      ptch_rt_q <= '0;
      vld_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      offset_q  <= offset_d;
      int_q     <= int_d;
      ptch_rt_q <= ptch_rt_d;
      vld_q     <= vld_d;
    end
  end

  assign ptch    = ptch_cur;
  assign ptch_rt = ptch_rt_q;
  assign vld     = vld_q;

endmodule

// File: tb/tb_inertial_integrator.sv
// tb/tb_inertial_integrator.sv - randomized bench for inertial_integrator against an arithmetic model
module tb_inertial_integrator;
  localparam int                 CAL_LOG2  = 4;
  localparam logic signed [15:0] AZ_OFFSET = 16'sh0000;
  localparam int                 NCAL      = 1 << CAL_LOG2;
`ifdef INERTIAL_FUSION_EN
  localparam bit FUS = 1'b1;
`else
  localparam bit FUS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, smpl_vld, clr_int;
  logic signed [15:0] ptch_rt_raw, AZ;
  logic signed [15:0] ptch, ptch_rt;
  logic vld, cal_done;

  always #5 clk = ~clk;

  inertial_integrator #(.CAL_LOG2(CAL_LOG2), .AZ_OFFSET(AZ_OFFSET)) dut (
    .clk(clk), .rst_n(rst_n), .smpl_vld(smpl_vld), .ptch_rt_raw(ptch_rt_raw),
    .AZ(AZ), .clr_int(clr_int), .ptch(ptch), .ptch_rt(ptch_rt), .vld(vld),
    .cal_done(cal_done)
  );

  int errors = 0;
  int checks = 0;

  bit          m_run, m_vld;
  int          m_cnt;
  longint      m_sum, m_off, m_int;
  logic [15:0] m_rt;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_ptch();
    return 16'(m_int >>> 11);
  endfunction

  task automatic model_reset();
    m_run = 0; m_vld = 0; m_cnt = 0; m_sum = 0; m_off = 0; m_int = 0; m_rt = '0;
  endtask

  task automatic model_update(input bit s, input logic [15:0] raw, input logic [15:0] az, input bit clr);
    longint rc, pa, p, f;
    m_vld = 0;
    if (!m_run) begin
      if (s) begin
        m_sum += longint'(signed'(raw));
        m_cnt++;
        if (m_cnt == NCAL) begin
          m_off = m_sum >>> CAL_LOG2;
          m_run = 1;
        end
      end
    end else if (clr) begin
      m_int = 0;
    end else if (s) begin
      rc = longint'(signed'(raw)) - m_off;
      if (rc > 32767) rc = 32767;
      if (rc < -32768) rc = -32768;
      p  = m_int >>> 11;
      pa = (longint'(signed'(16'(az - AZ_OFFSET))) * 327) >>> 13;
      f  = 0;
      if (FUS) f = (pa > p) ? 1024 : ((pa < p) ? -1024 : 0);
      m_int = m_int - rc + f;
      if (m_int > 67108863) m_int = 67108863;
      if (m_int < -67108864) m_int = -67108864;
      m_rt  = 16'(rc);
      m_vld = 1;
    end
  endtask

  task automatic check_outputs();
    check("vld", 16'(vld), 16'(m_vld));
    check("cal_done", 16'(cal_done), 16'(m_run));
    check("ptch", ptch, m_ptch());
    check("ptch_rt", ptch_rt, m_rt);
  endtask

  task automatic step(input bit s, input logic [15:0] raw, input logic [15:0] az, input bit clr);
    smpl_vld = s; ptch_rt_raw = raw; AZ = az; clr_int = clr;
    @(posedge clk); #1;
    model_update(s, raw, az, clr);
    check_outputs();
    smpl_vld = 0; clr_int = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; smpl_vld = 0; clr_int = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    rst_n = 1;
  endtask

  task automatic calibrate(input logic [15:0] raw);
    for (int i = 0; i < NCAL; i++) step(1, raw, 16'h0000, 0);
  endtask

  initial begin
    rst_n = 0; smpl_vld = 0; clr_int = 0; ptch_rt_raw = '0; AZ = '0;
    model_reset();

    do_reset();
    for (int i = 0; i < NCAL - 1; i++) step(1, 16'h0040, 16'h0000, 0);
    check("cal_15_done", 16'(cal_done), 16'h0000);
    step(1, 16'h0040, 16'h0000, 0);
    check("cal_16_done", 16'(cal_done), 16'h0001);
    step(1, 16'h0040, 16'h0000, 0);
    check("first_vld", 16'(vld), 16'h0001);
    check("first_rt", ptch_rt, 16'h0000);
    check("first_ptch", ptch, 16'h0000);
    step(0, 16'h0040, 16'h0000, 0);
    check("vld_one_cycle", 16'(vld), 16'h0000);

    do_reset();
    calibrate(16'h0000);
    for (int i = 0; i < 4; i++) begin
      step(1, 16'h0800, 16'h0000, 0);
      check("int_rt", ptch_rt, 16'h0800);
    end

    do_reset();
    calibrate(16'h0000);
    for (int i = 0; i < 20; i++) step(1, 16'h0000, 16'h2000, 0);

    do_reset();
    calibrate(16'h0100);
    step(1, 16'h8000, 16'h0000, 0);
    check("rt_sat_neg", ptch_rt, 16'h8000);
    step(1, 16'h0100, 16'h0000, 1);
    check("clr_no_vld", 16'(vld), 16'h0000);
    check("clr_ptch", ptch, 16'h0000);

    do_reset();
    for (int i = 0; i < 8; i++) step(1, 16'h0010, 16'h0000, 0);
    do_reset();
    for (int i = 0; i < NCAL - 1; i++) step(1, 16'h0010, 16'h0000, 0);
    check("recal_15_done", 16'(cal_done), 16'h0000);
    step(1, 16'h0010, 16'h0000, 0);
    check("recal_16_done", 16'(cal_done), 16'h0001);

    do_reset();
    calibrate(16'h0000);
    for (int i = 0; i < 2200; i++) step(1, 16'h8000, 16'h8000, 0);
    check("int_sat_pos", ptch, 16'h7FFF);
    step(0, 16'h0000, 16'h0000, 1);
    for (int i = 0; i < 2200; i++) step(1, 16'h7FFF, 16'h7FFF, 0);
    check("int_sat_neg", ptch, 16'h8000);

    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 40; i++)
        step(($urandom % 3) != 0, 16'($urandom_range(0, 16'hFFFF)), 16'($urandom), ($urandom % 5) == 0);
      for (int i = 0; i < 1500; i++) begin
        logic [15:0] raw;
        case ($urandom % 4)
          0:       raw = 16'h8000;
          1:       raw = 16'h7FFF;
          default: raw = 16'($urandom_range(0, 1023)) - 16'd512;
        endcase
        step(($urandom % 4) != 0, raw, 16'($urandom), ($urandom % 25) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inertial_integrator.md
# inertial_integrator

Producer side of the pitch interface that feeds the balance controller. Takes raw gyro pitch-rate and accelerometer Z samples from the inertial sensor front end and removes the gyro offset, which it learns during a start-up calibration window. It integrates the corrected rate into a pitch estimate, optionally pulls that estimate toward an accelerometer-derived pitch, and outputs `ptch`, `ptch_rt` and a one-cycle `vld` strobe.

## Interface
- `CAL_LOG2`, 4: calibration averages 2^CAL_LOG2 samples; legal range 2..10.
- `AZ_OFFSET`, 16'sh0000: accelerometer Z offset subtracted before the pitch conversion.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock domain; synchronous and active-low.
- `smpl_vld`  in  1  one-cycle strobe; raw inputs are valid this cycle.
- `ptch_rt_raw`  in  16  signed raw gyro pitch rate.
- `AZ`  in  16  signed raw accelerometer Z.
- `clr_int`  in  1  synchronous clear of the pitch integrator; the offset is kept.
- `ptch`  out  16  signed pitch estimate.
- `ptch_rt`  out  16  signed offset-corrected pitch rate.
- `vld`  out  1  one-cycle strobe; `ptch` and `ptch_rt` are updated this cycle.
- `cal_done`  out  1  high once the offset is latched.

## Operation
- **States:**
  - CAL: reset state.
  - RUN: entered the cycle after the 2^CAL_LOG2-th `smpl_vld` in CAL.
  - RUN is left only by reset.
- **CAL:**
  - Each `smpl_vld` adds sign-extended `ptch_rt_raw` into a (16+CAL_LOG2)-bit signed accumulator and increments the sample counter.
  - On the last sample, `offset` = accumulator >>> CAL_LOG2 (arithmetic shift, truncating).
  - `vld`, `ptch` and `ptch_rt` stay 0 throughout CAL.
  - Samples used for calibration are never integrated.
- **RUN, on each `smpl_vld`:**
  - `rt_corr` = `ptch_rt_raw` − `offset`, computed at 17 bits and saturated to 16 bits (7FFF / 8000).
  - `ptch_acc`:
    - `AZ_comp` = `AZ` − `AZ_OFFSET` (16-bit, wraps).
    - `prod` = `AZ_comp` × 327, 26-bit signed.
    - `ptch_acc` = sign-extended `prod[25:13]`.
  - `fus`:
    - +1024 if `ptch_acc` > current `ptch`.
    - −1024 if `ptch_acc` < current `ptch`.
    - 0 if they are equal.
  - `int` (27-bit signed) ← `int` − sext(`rt_corr`) + `fus`, saturated at 27-bit signed limits; it never wraps.
  - `ptch` = `int[26:11]`, taken from the updated `int`.
  - `ptch_rt` = `rt_corr`.
- **`clr_int` in RUN:** `int` ← 0 and `ptch` ← 0 next cycle. If it coincides with `smpl_vld`, the clear wins, the sample is dropped and `vld` stays 0. `clr_int` is ignored in CAL.
- **Reset:** a low `rst_n` at any point, including mid-calibration, returns the block to CAL and clears the accumulator, counter, offset and `int`. Calibration then restarts from zero samples.

## Timing
- **Reset values:**
  - `ptch` = 0.
  - `ptch_rt` = 0.
  - `vld` = 0.
  - `cal_done` = 0.
  - State = CAL.
- **Latency:** 1 cycle. A `smpl_vld` in cycle N (RUN) gives registered `ptch`, `ptch_rt` and `vld`=1 in cycle N+1.
- **`vld`:** high for exactly one cycle per accepted sample. Outputs hold their values between strobes.
- **`cal_done`:** rises in the cycle after the final calibration sample, in the same cycle the state becomes RUN. The first sample that can be integrated arrives at the earliest in that cycle.
- **Sample rate:** back-to-back `smpl_vld` (every cycle) is supported with no gaps in `vld`.
- **Fusion compare:** uses `ptch` as registered before the update.

## Configuration
- **`INERTIAL_FUSION_EN` defined:** `fus` is applied as described in Operation.
- **`INERTIAL_FUSION_EN` undefined:**
  - `fus` ≡ 0; pure gyro integration.
  - `AZ` is unused.
  - The multiplier is not synthesized.

## Test plan
- **Reset values:** hold `rst_n`=0 for 2 cycles → `ptch`=0, `ptch_rt`=0, `vld`=0, `cal_done`=0. With `smpl_vld` pulsed 15 times (CAL_LOG2=4) → `cal_done` still 0 and `vld` never asserted.
- **Calibration:** 16 samples of `ptch_rt_raw`=16'h0040 → `cal_done`=1 the cycle after the 16th sample. Next sample with `ptch_rt_raw`=16'h0040, `AZ`=0 → `vld` pulses 1 cycle later with `ptch_rt`=0 and `ptch`=0.
- **Integration, fusion off:**
  - Stimulus: calibrate on 0, then 4 samples of 16'h0800.
  - Required response: `ptch_rt`=16'h0800 each strobe; `int`=−0x2000; final `ptch`=16'hFFFC.
- **Fusion on:**
  - Stimulus: calibrate on 0, then 20 samples of rate 0 with `AZ`=16'h2000.
  - Required response: `ptch_acc`=327; `int`=20480; `ptch`=10.
- **Rate saturation:** calibrate on 16'h0100, then `ptch_rt_raw`=16'h8000 → `ptch_rt`=16'h8000 (saturated, not wrapped).
- **Clear and reset mid-operation:**
  - `clr_int` together with `smpl_vld` → no `vld`, and `ptch`=0 next cycle.
  - `rst_n` pulsed low after 8 calibration samples → 16 further samples are needed before `cal_done`.
